// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache data array.
// Widths are derived from the defaults so other blocks can size against them.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, EVICT_RD, EVICT} cache_state_e;

    localparam int DEF_WAYS   = 4;
    localparam int DEF_SETS   = 128;
    localparam int DEF_WORDS  = 16;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_BEAT_W = 128;

    // clog2 that never returns 0, so single-entry dimensions still get a 1-bit field
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_BEATS = DEF_WORDS * DEF_WORD_W / DEF_BEAT_W;
    localparam int DEF_WAY_W = clog2w(DEF_WAYS);
    localparam int DEF_IDX_W = clog2w(DEF_SETS);
    localparam int DEF_OFF_W = clog2w(DEF_WORDS);
    localparam int DEF_CNT_W = clog2w(DEF_BEATS);

endpackage

// File: rtl/cache_data_array_if.sv
// CPU word port, refill beat port and evict beat port of the cache data array.
// master = cache controller / memory side, slave = data array.
interface cache_data_array_if
    import cache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int WORDS  = DEF_WORDS,
    parameter int WORD_W = DEF_WORD_W,
    parameter int BEAT_W = DEF_BEAT_W
);
    localparam int WAY_W = clog2w(WAYS);
    localparam int IDX_W = clog2w(SETS);
    localparam int OFF_W = clog2w(WORDS);

    logic              cpu_req;
    logic              cpu_ready;
    logic              cpu_we;
    logic [WAY_W-1:0]  cpu_way;
    logic [IDX_W-1:0]  cpu_index;
    logic [OFF_W-1:0]  cpu_offset;
    logic [WORD_W/8-1:0] cpu_be;
    logic [WORD_W-1:0] cpu_wdata;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_perr;
    logic              refill_start;
    logic              evict_start;
    logic [WAY_W-1:0]  xfer_way;
    logic [IDX_W-1:0]  xfer_index;
    logic              refill_valid;
    logic [BEAT_W-1:0] refill_data;
    logic              refill_ready;
    logic              evict_valid;
    logic [BEAT_W-1:0] evict_data;
    logic              evict_ready;
    logic              evict_perr;
    logic              xfer_done;

    modport master (
        output cpu_req, cpu_we, cpu_way, cpu_index, cpu_offset, cpu_be, cpu_wdata,
               refill_start, evict_start, xfer_way, xfer_index,
               refill_valid, refill_data, evict_ready,
        input  cpu_ready, cpu_rdata, cpu_rvalid, cpu_perr,
               refill_ready, evict_valid, evict_data, evict_perr, xfer_done
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_way, cpu_index, cpu_offset, cpu_be, cpu_wdata,
               refill_start, evict_start, xfer_way, xfer_index,
               refill_valid, refill_data, evict_ready,
        output cpu_ready, cpu_rdata, cpu_rvalid, cpu_perr,
               refill_ready, evict_valid, evict_data, evict_perr, xfer_done
    );

endinterface

// File: rtl/data_array_bank.sv
// One way of block storage: SETS x BLK_W bits, byte-masked write, registered read.
// With DATA_ARRAY_PARITY_EN an even-parity bit per byte is kept beside the data.
module data_array_bank #(
    parameter int SETS  = 128,
    parameter int BLK_W = 512,
    parameter int IDX_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [BLK_W/8-1:0] wmask,
    input  logic [BLK_W-1:0]   wdata,
    input  logic               re,
    input  logic [IDX_W-1:0]   ridx,
    output logic [BLK_W-1:0]   rdata
`ifdef DATA_ARRAY_PARITY_EN
   ,output logic [BLK_W/8-1:0] rpar
`endif
);
    localparam int BLK_B = BLK_W / 8;

    logic [BLK_W-1:0] mem [SETS];

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < BLK_B; b++)
                if (wmask[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[ridx];
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [BLK_B-1:0] par [SETS];

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < BLK_B; b++)
                if (wmask[b]) par[widx][b] <= ^wdata[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rpar <= '0;
        else if (re) rpar <= par[ridx];
    end
`endif

endmodule

// File: rtl/cache_data_array.sv
// N-way cache data store: CPU word port plus beat-serial refill and eviction.
// Optional per-byte parity under DATA_ARRAY_PARITY_EN.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int WORDS  = DEF_WORDS,
    parameter int WORD_W = DEF_WORD_W,
    parameter int BEAT_W = DEF_BEAT_W
) (
    input logic clk,
    input logic rst_n,
    cache_data_array_if.slave bus
);
    localparam int BEATS = WORDS * WORD_W / BEAT_W;
    localparam int BLK_W = WORDS * WORD_W;
    localparam int BLK_B = BLK_W / 8;
    localparam int WB    = WORD_W / 8;
    localparam int BB    = BEAT_W / 8;
    localparam int WAY_W = clog2w(WAYS);
    localparam int IDX_W = clog2w(SETS);
    localparam int OFF_W = clog2w(WORDS);
    localparam int CNT_W = clog2w(BEATS);

    cache_state_e     state, state_nx;
    logic             run_q, rvalid_q, done_q, done_nx, latch;
    logic [CNT_W-1:0] cnt, cnt_nx, beat_q;
    logic [WAY_W-1:0] way_q, rway_q, rd_way, wr_way;
    logic [IDX_W-1:0] idx_q, rd_idx, wr_idx;
    logic [OFF_W-1:0] roff_q;
    logic             re, we, cpu_acc, last;
    logic [BLK_B-1:0] wmask;
    logic [BLK_W-1:0] wdata, rblk;
    logic [WAYS-1:0][BLK_W-1:0] rdata;

    // run_q keeps the CPU port closed until the first edge after reset release
    assign bus.cpu_ready = run_q & (state == IDLE) & ~bus.refill_start & ~bus.evict_start;
    assign cpu_acc       = bus.cpu_req & bus.cpu_ready;
    assign last          = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        done_nx  = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
        rd_way   = bus.cpu_way;
        rd_idx   = bus.cpu_index;
        wr_way   = bus.cpu_way;
        wr_idx   = bus.cpu_index;
        wmask    = '0;
        wdata    = {WORDS{bus.cpu_wdata}};
        unique case (state)
            IDLE: begin
                if (run_q && bus.evict_start) begin
                    state_nx = EVICT_RD;
                    latch    = 1'b1;
                    cnt_nx   = '0;
                end else if (run_q && bus.refill_start) begin
                    state_nx = REFILL;
                    latch    = 1'b1;
                    cnt_nx   = '0;
                end else if (cpu_acc) begin
                    if (bus.cpu_we) begin
                        we    = 1'b1;
                        wmask = BLK_B'(bus.cpu_be) << (32'(bus.cpu_offset) * WB);
                    end else begin
                        re = 1'b1;
                    end
                end
            end
            REFILL: begin
                if (bus.refill_valid) begin
                    we     = 1'b1;
                    wr_way = way_q;
                    wr_idx = idx_q;
                    wdata  = {BEATS{bus.refill_data}};
                    wmask  = BLK_B'({BB{1'b1}}) << (32'(cnt) * BB);
                    cnt_nx = cnt + 1'b1;
                    if (last) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            EVICT_RD: begin
                re       = 1'b1;
                rd_way   = way_q;
                rd_idx   = idx_q;
                state_nx = EVICT;
            end
            EVICT: begin
                if (bus.evict_ready) begin
                    cnt_nx = cnt + 1'b1;
                    if (last) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = EVICT_RD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            cnt      <= '0;
            beat_q   <= '0;
            way_q    <= '0;
            idx_q    <= '0;
            rway_q   <= '0;
            roff_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            state    <= state_nx;
            cnt      <= cnt_nx;
            done_q   <= done_nx;
            rvalid_q <= re & (state == IDLE);
            if (latch) begin
                way_q <= bus.xfer_way;
                idx_q <= bus.xfer_index;
            end
            if (re) rway_q <= rd_way;
            if (re && state == IDLE) roff_q <= bus.cpu_offset;
            if (state == EVICT_RD) beat_q <= cnt;
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [WAYS-1:0][BLK_B-1:0] rpar;
`endif

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        data_array_bank #(.SETS(SETS), .BLK_W(BLK_W), .IDX_W(IDX_W)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we && wr_way == WAY_W'(w)),
            .widx  (wr_idx),
            .wmask (wmask),
            .wdata (wdata),
            .re    (re && rd_way == WAY_W'(w)),
            .ridx  (rd_idx),
            .rdata (rdata[w])
`ifdef DATA_ARRAY_PARITY_EN
           ,.rpar  (rpar[w])
`endif
        );
    end

    // Bank outputs hold between reads, so evict_data stays stable while stalled
    assign rblk             = rdata[rway_q];
    assign bus.cpu_rdata    = rblk[32'(roff_q) * WORD_W +: WORD_W];
    assign bus.cpu_rvalid   = rvalid_q;
    assign bus.evict_data   = rblk[32'(beat_q) * BEAT_W +: BEAT_W];
    assign bus.evict_valid  = (state == EVICT);
    assign bus.refill_ready = (state == REFILL);
    assign bus.xfer_done    = done_q;

`ifdef DATA_ARRAY_PARITY_EN
    logic [BLK_B-1:0] rpblk, pmis;
    assign rpblk = rpar[rway_q];
    always_comb begin
        pmis = '0;
        for (int b = 0; b < BLK_B; b++) pmis[b] = (^rblk[b*8 +: 8]) ^ rpblk[b];
    end
    assign bus.cpu_perr   = rvalid_q & (|pmis[32'(roff_q) * WB +: WB]);
    assign bus.evict_perr = bus.evict_valid & (|pmis[32'(beat_q) * BB +: BB]);
`else
    assign bus.cpu_perr   = 1'b0;
    assign bus.evict_perr = 1'b0;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: CPU byte writes/reads, refill, eviction,
// start priority, asynchronous reset mid-refill and parity reporting.
module tb_cache_data_array;

    logic clk = 1'b0;
    logic rst_n;
    int   chk = 0;
    int   err = 0;
    int   done_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    cache_data_array_if bus ();
    cache_data_array dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(negedge clk) if (bus.xfer_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        logic [7:0] a, c;
        a = 8'hA0 + 8'(w);
        c = 8'h10 + 8'(w);
        return {a, 8'h5A, c, 8'hC3};
    endfunction

    function automatic logic [127:0] beat_of(input int k);
        return {word_of(4*k+3), word_of(4*k+2), word_of(4*k+1), word_of(4*k)};
    endfunction

    task automatic cpu_write(input int way, input int idx, input int off,
                             input logic [3:0] be, input logic [31:0] d);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_way = 2'(way); bus.cpu_index = 7'(idx); bus.cpu_offset = 4'(off);
        bus.cpu_be = be; bus.cpu_wdata = d;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        check("wr_no_rvalid", bus.cpu_rvalid, 1'b0);
    endtask

    task automatic cpu_read(input int way, input int idx, input int off,
                            input logic [31:0] exp, input logic exp_perr, input string tag);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        bus.cpu_way = 2'(way); bus.cpu_index = 7'(idx); bus.cpu_offset = 4'(off);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        check({tag, "_rvalid"}, bus.cpu_rvalid, 1'b1);
        check({tag, "_rdata"}, bus.cpu_rdata, exp);
        check({tag, "_perr"}, bus.cpu_perr, exp_perr);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_way = 0; bus.cpu_index = 0;
        bus.cpu_offset = 0; bus.cpu_be = 0; bus.cpu_wdata = 0;
        bus.refill_start = 0; bus.evict_start = 0; bus.xfer_way = 0; bus.xfer_index = 0;
        bus.refill_valid = 0; bus.refill_data = 0; bus.evict_ready = 0;

        repeat (2) @(posedge clk); #1;
        check("rst_cpu_ready", bus.cpu_ready, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_cpu_perr", bus.cpu_perr, 1'b0);
        check("rst_refill_ready", bus.refill_ready, 1'b0);
        check("rst_evict_valid", bus.evict_valid, 1'b0);
        check("rst_evict_data", bus.evict_data, 128'h0);
        check("rst_evict_perr", bus.evict_perr, 1'b0);
        check("rst_xfer_done", bus.xfer_done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", bus.cpu_ready, 1'b1);

        // byte-enable writes and write-then-read visibility
        cpu_write(2, 5, 3, 4'hF, 32'hDEADBEEF);
        cpu_read(2, 5, 3, 32'hDEADBEEF, 1'b0, "rd_full");
        cpu_write(2, 5, 3, 4'h3, 32'h0000CAFE);
        cpu_read(2, 5, 3, 32'hDEADCAFE, 1'b0, "rd_be3");
        cpu_write(2, 5, 3, 4'h0, 32'hFFFFFFFF);
        cpu_read(2, 5, 3, 32'hDEADCAFE, 1'b0, "rd_be0");
        cpu_write(0, 5, 3, 4'hF, 32'h0BADF00D);
        cpu_write(2, 5, 4, 4'hF, 32'h12345678);

        // back-to-back reads across ways
        bus.cpu_req = 1'b1; bus.cpu_way = 2; bus.cpu_index = 5; bus.cpu_offset = 3;
        @(posedge clk); #1;
        bus.cpu_offset = 4;
        check("b2b0_rvalid", bus.cpu_rvalid, 1'b1);
        check("b2b0_rdata", bus.cpu_rdata, 32'hDEADCAFE);
        @(posedge clk); #1;
        bus.cpu_way = 0; bus.cpu_offset = 3;
        check("b2b1_rvalid", bus.cpu_rvalid, 1'b1);
        check("b2b1_rdata", bus.cpu_rdata, 32'h12345678);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        check("b2b2_rdata", bus.cpu_rdata, 32'h0BADF00D);
        @(posedge clk); #1;
        check("b2b_idle_rvalid", bus.cpu_rvalid, 1'b0);

        // refill way 1 set 127, beat 2 delayed three cycles
        base = done_cnt;
        bus.xfer_way = 1; bus.xfer_index = 127; bus.refill_start = 1'b1;
        #1 check("rf_start_blocks_cpu", bus.cpu_ready, 1'b0);
        @(posedge clk); #1;
        bus.refill_start = 1'b0;
        check("rf_ready", bus.refill_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                repeat (3) @(posedge clk); #1;
                check("rf_stall_ready", bus.refill_ready, 1'b1);
                check("rf_stall_nodone", bus.xfer_done, 1'b0);
            end
            bus.refill_valid = 1'b1; bus.refill_data = beat_of(k);
            @(posedge clk); #1;
            bus.refill_valid = 1'b0;
        end
        check("rf_done", bus.xfer_done, 1'b1);
        check("rf_back_idle", bus.refill_ready, 1'b0);
        @(posedge clk); #1;
        check("rf_done_pulse", bus.xfer_done, 1'b0);
        for (int w = 0; w < 16; w++) cpu_read(1, 127, w, word_of(w), 1'b0, "rf_word");
        check("rf_done_count", 32'(done_cnt - base), 32'd1);

        // evict the same block with evict_ready toggling; CPU request held
        base = done_cnt;
        bus.evict_start = 1'b1; bus.cpu_req = 1'b1; bus.cpu_way = 0; bus.cpu_offset = 0;
        @(posedge clk); #1;
        bus.evict_start = 1'b0;
        check("ev_rd_valid", bus.evict_valid, 1'b0);
        check("ev_cpu_ready", bus.cpu_ready, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check("ev_valid", bus.evict_valid, 1'b1);
            check("ev_data", bus.evict_data, beat_of(k));
            check("ev_cpu_blocked", bus.cpu_ready, 1'b0);
            @(posedge clk); #1;
            check("ev_stall_valid", bus.evict_valid, 1'b1);
            check("ev_stall_data", bus.evict_data, beat_of(k));
            check("ev_perr", bus.evict_perr, 1'b0);
            bus.evict_ready = 1'b1;
            @(posedge clk); #1;
            bus.evict_ready = 1'b0;
            if (k < 3) begin
                check("ev_gap_valid", bus.evict_valid, 1'b0);
                check("ev_gap_nodone", bus.xfer_done, 1'b0);
                check("ev_gap_rvalid", bus.cpu_rvalid, 1'b0);
                @(posedge clk); #1;
            end
        end
        bus.cpu_req = 1'b0;
        check("ev_done", bus.xfer_done, 1'b1);
        check("ev_end_valid", bus.evict_valid, 1'b0);
        check("ev_end_rvalid", bus.cpu_rvalid, 1'b0);
        @(posedge clk); #1;
        check("ev_done_count", 32'(done_cnt - base), 32'd1);

        // all three requests together: eviction wins, CPU not accepted
        bus.refill_start = 1'b1; bus.evict_start = 1'b1; bus.cpu_req = 1'b1;
        bus.xfer_way = 1; bus.xfer_index = 127;
        #1 check("prio_cpu_ready", bus.cpu_ready, 1'b0);
        @(posedge clk); #1;
        bus.refill_start = 1'b0; bus.evict_start = 1'b0; bus.cpu_req = 1'b0;
        check("prio_not_refill", bus.refill_ready, 1'b0);
        check("prio_no_rvalid", bus.cpu_rvalid, 1'b0);
        @(posedge clk); #1;
        check("prio_evict", bus.evict_valid, 1'b1);
        check("prio_evict_data", bus.evict_data, beat_of(0));
        bus.evict_ready = 1'b1;
        for (int i = 0; i < 20 && bus.xfer_done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("prio_done", bus.xfer_done, 1'b1);
        bus.evict_ready = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset in the middle of a refill
        bus.xfer_way = 3; bus.xfer_index = 0; bus.refill_start = 1'b1;
        @(posedge clk); #1;
        bus.refill_start = 1'b0;
        bus.refill_valid = 1'b1; bus.refill_data = beat_of(1);
        @(posedge clk); #1;
        bus.refill_valid = 1'b0;
        check("mid_rf_ready", bus.refill_ready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_refill_ready", bus.refill_ready, 1'b0);
        check("arst_cpu_ready", bus.cpu_ready, 1'b0);
        check("arst_evict_valid", bus.evict_valid, 1'b0);
        check("arst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("arst_evict_data", bus.evict_data, 128'h0);
        check("arst_xfer_done", bus.xfer_done, 1'b0);
        check("arst_rvalid", bus.cpu_rvalid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_release_ready", bus.cpu_ready, 1'b1);
        check("arst_release_idle", bus.refill_ready, 1'b0);

        // stored data survives reset; parity reporting
        cpu_read(2, 5, 3, 32'hDEADCAFE, 1'b0, "post_rst_rd");
`ifdef DATA_ARRAY_PARITY_EN
        dut.g_way[2].u_bank.mem[5][96] = ~dut.g_way[2].u_bank.mem[5][96];
        cpu_read(2, 5, 3, 32'hDEADCAFF, 1'b1, "perr_flip");
        cpu_read(2, 5, 4, 32'h12345678, 1'b0, "perr_clean");
`else
        cpu_read(2, 5, 4, 32'h12345678, 1'b0, "perr_tied");
`endif

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
